// File: rtl/pwm_capture_if.sv
// Port bundle for pwm_capture: PWM input plus the published measurement and stuck status.
// fsm_state is a debug view of the capture FSM (0 IDLE, 1 HIGH, 2 LOW).
interface pwm_capture_if #(
  parameter int CNT_W = 20
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             stuck;
  logic             stuck_level;
  logic [1:0]       fsm_state;

  // Handshake: meas_valid is a valid-only strobe with no ready. It is high for
  // exactly one cycle, and high_time/period are stable from that cycle until the next strobe or timeout.
  modport master (
    output pwm_in,
    input  high_time, period, meas_valid, stuck, stuck_level, fsm_state
  );

  modport slave (
    input  pwm_in,
    output high_time, period, meas_valid, stuck, stuck_level, fsm_state
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM high-time / period meter with stuck-input detection, all counted in sys_clk cycles.
// Optional stability filter after the synchroniser: define PWM_CAP_DEGLITCH_EN.
module pwm_capture #(
  parameter int               CNT_W      = 20,
  parameter logic [CNT_W-1:0] TIMEOUT    = 20'd20_000,
  parameter int               FILTER_LEN = 4
) (
  input logic          sys_clk,
  input logic          sys_rst,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reject parameter sets that would let a counter wrap or the filter counter overflow.
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("pwm_capture: CNT_W must be at least 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT must be at least 2");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("pwm_capture: FILTER_LEN must be in 1..15");
  end

  logic sync_a;
  logic sync_b;
  logic pwm_s;
  logic pwm_d;
  logic rise;
  logic fall;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= bus.pwm_in;
      sync_b <= sync_a;
    end
  end

`ifdef PWM_CAP_DEGLITCH_EN
  logic       flt_level;
  logic [3:0] flt_cnt;

  // The filtered level only follows sync_b after FILTER_LEN consecutive cycles of disagreement.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      flt_level <= 1'b0;
      flt_cnt   <= 4'd0;
    end else if (sync_b == flt_level) begin
      flt_cnt <= 4'd0;
    end else if (flt_cnt == 4'(FILTER_LEN - 1)) begin
      flt_level <= sync_b;
      flt_cnt   <= 4'd0;
    end else begin
      flt_cnt <= flt_cnt + 4'd1;
    end
  end

  assign pwm_s = flt_level;
`else
  assign pwm_s = sync_b;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pwm_d <= 1'b0;
    end else begin
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] per_acc;
  logic [CNT_W-1:0] per_n;
  logic [CNT_W-1:0] hi_acc;
  logic [CNT_W-1:0] hi_n;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_n;
  logic [CNT_W-1:0] high_time_q;
  logic [CNT_W-1:0] high_time_n;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_n;
  logic             valid_q;
  logic             valid_n;
  logic             stuck_q;
  logic             stuck_n;
  logic             level_q;
  logic             level_n;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      per_acc     <= '0;
      hi_acc      <= '0;
      idle_cnt    <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state       <= state_n;
      per_acc     <= per_n;
      hi_acc      <= hi_n;
      idle_cnt    <= idle_n;
      high_time_q <= high_time_n;
      period_q    <= period_n;
      valid_q     <= valid_n;
      stuck_q     <= stuck_n;
      level_q     <= level_n;
    end
  end

  always_comb begin
    state_n     = state;
    per_n       = per_acc;
    hi_n        = hi_acc;
    idle_n      = idle_cnt;
    high_time_n = high_time_q;
    period_n    = period_q;
    valid_n     = 1'b0;
    stuck_n     = stuck_q;
    level_n     = level_q;

    case (state)
      IDLE: begin
        if (rise) begin
          state_n = HIGH;
          per_n   = ONE;
          hi_n    = ONE;
          idle_n  = '0;
          stuck_n = 1'b0;
        end else if (idle_cnt == TIMEOUT - ONE) begin
          // Parking the counter at TIMEOUT keeps the stuck event from re-firing.
          idle_n      = TIMEOUT;
          stuck_n     = 1'b1;
          level_n     = pwm_s;
          high_time_n = '0;
          period_n    = '0;
        end else if (idle_cnt != TIMEOUT) begin
          idle_n = idle_cnt + ONE;
        end
      end

      HIGH, LOW: begin
        if (rise) begin
          // A rise beats a same-cycle timeout; only a rise out of LOW closes a period.
          state_n = HIGH;
          per_n   = ONE;
          hi_n    = ONE;
          stuck_n = 1'b0;
          if (state == LOW) begin
            high_time_n = hi_acc;
            period_n    = per_acc;
            valid_n     = 1'b1;
          end
        end else if (per_acc == TIMEOUT) begin
          state_n     = IDLE;
          idle_n      = TIMEOUT;
          stuck_n     = 1'b1;
          level_n     = pwm_s;
          high_time_n = '0;
          period_n    = '0;
        end else begin
          per_n = per_acc + ONE;
          if (pwm_s) begin
            hi_n = hi_acc + ONE;
          end
          if (fall && state == HIGH) begin
            state_n = LOW;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.high_time   = high_time_q;
  assign bus.period      = period_q;
  assign bus.meas_valid  = valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = level_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (TIMEOUT=50): waveform table, strobe scoreboard and
// hand-timed sequences for latency, timeout, reset and glitch behaviour.
module tb_pwm_capture;

  localparam int CNT_W = 20;
  localparam int W     = 2 * CNT_W;
`ifdef PWM_CAP_DEGLITCH_EN
  localparam int F = 4;
`else
  localparam int F = 0;
`endif
  localparam int LAT = 3 + F;
  localparam int HL  = LAT + 1;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_hi;
    int exp_per;
  } vec_t;

  logic sys_clk;
  logic sys_rst;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (20'd50),
    .FILTER_LEN (4)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  vec_t vecs[$];

  always @(posedge sys_clk) begin
    #2;
    if (bus.meas_valid === 1'b1) got_q.push_back({bus.high_time, bus.period});
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst    = 1'b1;
    bus.pwm_in = 1'b0;
    tick(2);
    sys_rst = 1'b0;
  endtask

  task automatic drive_period(input int hi, input int lo);
    bus.pwm_in = 1'b1;
    tick(hi);
    bus.pwm_in = 1'b0;
    tick(lo);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int h, input int p);
    exp_q.push_back({CNT_W'(h), CNT_W'(p)});
  endtask

  task automatic check_sb(input string name);
    logic [W-1:0] e;
    logic [W-1:0] g;
    check({name, " strobe count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({name, " high_time"}, 32'(g[W-1:CNT_W]), 32'(e[W-1:CNT_W]));
      check({name, " period"}, 32'(g[CNT_W-1:0]), 32'(e[CNT_W-1:0]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " high_time"}, 32'(bus.high_time), 0);
    check({name, " period"}, 32'(bus.period), 0);
    check({name, " meas_valid"}, 32'(bus.meas_valid), 0);
    check({name, " stuck"}, 32'(bus.stuck), 0);
    check({name, " stuck_level"}, 32'(bus.stuck_level), 0);
    check({name, " fsm_state"}, 32'(bus.fsm_state), 0);
  endtask

  initial begin
`ifdef PWM_CAP_DEGLITCH_EN
    vecs.push_back('{hi: 4, lo: 6, reps: 3, exp_hi: 4, exp_per: 10});
    vecs.push_back('{hi: 8, lo: 5, reps: 3, exp_hi: 8, exp_per: 13});
    vecs.push_back('{hi: 20, lo: 30, reps: 2, exp_hi: 20, exp_per: 50});
    vecs.push_back('{hi: 5, lo: 4, reps: 2, exp_hi: 5, exp_per: 9});
`else
    vecs.push_back('{hi: 3, lo: 7, reps: 4, exp_hi: 3, exp_per: 10});
    vecs.push_back('{hi: 8, lo: 2, reps: 3, exp_hi: 8, exp_per: 10});
    vecs.push_back('{hi: 1, lo: 1, reps: 5, exp_hi: 1, exp_per: 2});
    vecs.push_back('{hi: 20, lo: 30, reps: 2, exp_hi: 20, exp_per: 50});
    vecs.push_back('{hi: 2, lo: 5, reps: 2, exp_hi: 2, exp_per: 7});
`endif

    sys_rst    = 1'b1;
    bus.pwm_in = 1'b0;
    do_reset();
    check_outputs_zero("reset");

    // Constant-low input from reset: stuck after exactly 50 cycles.
    tick(49);
    check("idle pre-timeout stuck", 32'(bus.stuck), 0);
    tick(1);
    check("idle timeout stuck", 32'(bus.stuck), 1);
    check("idle timeout stuck_level", 32'(bus.stuck_level), 0);
    check("idle timeout high_time", 32'(bus.high_time), 0);
    check("idle timeout meas_valid", 32'(bus.meas_valid), 0);

    // First rise only starts; the second publishes exactly LAT edges later.
    bus.pwm_in = 1'b1;
    tick(HL);
    check("first rise clears stuck", 32'(bus.stuck), 0);
    check("first rise no strobe", 32'(got_q.size()), 0);
    bus.pwm_in = 1'b0;
    tick(6);
    bus.pwm_in = 1'b1;
    tick(LAT - 1);
    check("latency early meas_valid", 32'(bus.meas_valid), 0);
    tick(1);
    check("latency meas_valid", 32'(bus.meas_valid), 1);
    check("latency high_time", 32'(bus.high_time), HL);
    check("latency period", 32'(bus.period), HL + 6);
    push_exp(HL, HL + 6);
    tick(1);
    check("strobe one cycle", 32'(bus.meas_valid), 0);
    bus.pwm_in = 1'b0;
    tick(6);
    push_exp(HL, HL + 6);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive_period(vecs[i].hi, vecs[i].lo);
        push_exp(vecs[i].exp_hi, vecs[i].exp_per);
      end
      check($sformatf("row%0d stuck", i), 32'(bus.stuck), 0);
    end

    // Final rise then held high: timeout 50 counted cycles after the rise.
    bus.pwm_in = 1'b1;
    tick(52 + F);
    check("high pre-timeout stuck", 32'(bus.stuck), 0);
    tick(1);
    check("high timeout stuck", 32'(bus.stuck), 1);
    check("high timeout stuck_level", 32'(bus.stuck_level), 1);
    check("high timeout high_time", 32'(bus.high_time), 0);
    check("high timeout period", 32'(bus.period), 0);
    check("high timeout meas_valid", 32'(bus.meas_valid), 0);
    check_sb("stream");

    // A later rise clears stuck, but stuck_level holds.
    bus.pwm_in = 1'b0;
    tick(6);
    bus.pwm_in = 1'b1;
    tick(LAT);
    check("rise clears stuck", 32'(bus.stuck), 0);
    check("rise keeps stuck_level", 32'(bus.stuck_level), 1);
    check("restart no strobe", 32'(bus.meas_valid), 0);
    check("restart fsm HIGH", 32'(bus.fsm_state), 1);
    tick(8 - LAT);
    bus.pwm_in = 1'b0;
    tick(5);
    bus.pwm_in = 1'b1;
    tick(LAT);
    check("pre-reset high_time", 32'(bus.high_time), 8);
    check("pre-reset period", 32'(bus.period), 13);
    push_exp(8, 13);
    tick(1);
    check_sb("pre-reset");

    // Reset in the middle of a high phase.
    sys_rst    = 1'b1;
    bus.pwm_in = 1'b0;
    tick(1);
    sys_rst = 1'b0;
    check_outputs_zero("mid-high reset");
    drive_period(6, 6);
    check("post-reset first rise no strobe", 32'(got_q.size()), 0);
    bus.pwm_in = 1'b1;
    tick(LAT + 1);
    push_exp(6, 12);
    check_sb("post-reset");

    // 2-cycle glitches inside a 20/30 waveform.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      drive_period(20, 10);
      drive_period(2, 18);
`ifdef PWM_CAP_DEGLITCH_EN
      push_exp(20, 50);
`else
      push_exp(20, 30);
      push_exp(2, 20);
`endif
    end
    bus.pwm_in = 1'b1;
    tick(LAT + 1);
    bus.pwm_in = 1'b0;
    check_sb("glitch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
